// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding, the
// captured request record and the wait-state counter width.
package dmem_pkg;

   // Wide enough for the largest wait-state count (LATENCY up to 7).
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables.
// A load registers the addressed word; a store updates only enabled lanes
// and leaves the read register untouched.
module dmem_array #(
   parameter  int DEPTH_WORDS = 1024,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [3:0]       wstrb,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Single access per enabled cycle: byte-lane write or registered read.
   // NOTE: storage carries no reset so it maps onto block RAM and survives reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time on a valid/ready
// port, waits LATENCY cycles, performs the access and holds the response
// until the initiator takes it.
// Optional macro DMEM_ERR_EN: flag misaligned or out-of-range addresses
// with rsp_err instead of wrapping the word index.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   dmem_req_t        req_in, req_q, acc;
   logic             accept, access, acc_err;
   logic             rsp_load, rsp_err_q;
   logic [31:0]      ram_rdata;

   assign req_in    = '{addr: req_addr, we: req_we, wdata: req_wdata, wstrb: req_wstrb};
   assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign accept    = req_valid & req_ready;

   // With no wait states the access happens on the accepting edge, so it
   // must use the live request rather than the captured copy.
   assign acc = (LATENCY == 0) ? req_in : req_q;

`ifdef DMEM_ERR_EN
   assign acc_err = (acc.addr[1:0] != 2'b00) || (acc.addr[31:2] >= 30'(DEPTH_WORDS));
`else
   logic unused_addr_bits;
   assign acc_err          = 1'b0;
   assign unused_addr_bits = ^{acc.addr[31:IDX_W+2], acc.addr[1:0]};
`endif

   // State and wait counter register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state, counter and memory-access strobe.
   // NOTE: every output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      access     = 1'b0;
      case (state)
         IDLE: ;
         WAIT: begin
            if (cnt == '0) begin
               state_next = RESP;
               access     = 1'b1;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (accept) begin
         if (LATENCY == 0) begin
            state_next = RESP;
            access     = 1'b1;
         end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
         end
      end
   end

   // Capture the request fields on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       req_q <= '0;
      else if (accept) req_q <= req_in;
   end

   // Response flags latched on the edge that enters RESP; held until the next access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_load  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else if (access) begin
         rsp_load  <= ~acc.we & ~acc_err;
         rsp_err_q <= acc_err;
      end
   end

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .en    (access & ~acc_err),
      .we    (acc.we),
      .wstrb (acc.wstrb),
      .idx   (acc.addr[IDX_W+1:2]),
      .wdata (acc.wdata),
      .rdata (ram_rdata)
   );

   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rsp_load ? ram_rdata : '0;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance a uses LATENCY=2, instance b uses
// LATENCY=0. Stimulus pushes the expected response into a per-instance
// queue on acceptance; a monitor compares every cycle a response is shown.
// Build with DMEM_ERR_EN defined to exercise the error-flag variant.
module tb_dmem_responder;

   localparam int LAT_A = 2;
   localparam int LAT_B = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        req_we    [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   exp_t q_a[$];
   exp_t q_b[$];
   bit   fresh [2] = '{1'b1, 1'b1};
   int   cyc;
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef DMEM_ERR_EN
   localparam logic [31:0] EXP_LD1000 = 32'h0000_0000;
   localparam logic        ERR_OOR    = 1'b1;
   localparam logic [31:0] EXP_LD13   = 32'h0000_0000;
   localparam logic [31:0] EXP_LD0    = 32'hCAFE_F00D;
`else
   localparam logic [31:0] EXP_LD1000 = 32'hCAFE_F00D;
   localparam logic        ERR_OOR    = 1'b0;
   localparam logic [31:0] EXP_LD13   = 32'hDEAD_BEAA;
   localparam logic [31:0] EXP_LD0    = 32'h5555_5555;
`endif

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_we(req_we[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_we(req_we[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected event missing (cycle %0d)", name, cyc);
   endtask

   // Scoreboard monitor step for one instance, run 2 time units after each falling edge.
   task automatic mon_step(input int w);
      exp_t x;
      bit   have;
      if (rsp_valid[w] !== 1'b1) return;
      have = (w == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
      if (!have) begin
         if (fresh[w]) fail_now($sformatf("unexpected_rsp_%0d", w));
         fresh[w] = rsp_ready[w];
         return;
      end
      x = (w == 0) ? q_a[0] : q_b[0];
      if (fresh[w]) begin
         check($sformatf("first_valid_cycle_%0d", w), cyc, x.due);
         fresh[w] = 1'b0;
      end
      check($sformatf("rsp_rdata_%0d", w), rsp_rdata[w], x.rdata);
      check($sformatf("rsp_err_%0d", w), {31'b0, rsp_err[w]}, {31'b0, x.err});
      if (rsp_ready[w]) begin
         if (w == 0) void'(q_a.pop_front());
         else        void'(q_b.pop_front());
         fresh[w] = 1'b1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         mon_step(0);
         mon_step(1);
      end
   end

   // Drive a request on the next falling edge.
   task automatic present(input int w, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      @(negedge clk);
      req_valid[w] = 1'b1;
      req_addr[w]  = addr;
      req_we[w]    = we;
      req_wdata[w] = wdata;
      req_wstrb[w] = wstrb;
   endtask

   // Wait (bounded) until the presented request is accepted; push its expected response.
   task automatic wait_accept(input int w, input logic [31:0] er, input logic ee, output int waited);
      exp_t x;
      waited = 0;
      forever begin
         #1;
         if (req_ready[w] === 1'b1) begin
            x.rdata = er;
            x.err   = ee;
            x.due   = cyc + 1 + ((w == 0) ? LAT_A : LAT_B);
            if (w == 0) q_a.push_back(x);
            else        q_b.push_back(x);
            @(posedge clk);
            return;
         end
         waited++;
         if (waited > 40) begin
            fail_now($sformatf("accept_timeout_%0d", w));
            req_valid[w] = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic issue(input int w, input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] er, input logic ee);
      int waited;
      present(w, addr, we, wdata, wstrb);
      wait_accept(w, er, ee, waited);
   endtask

   task automatic idle(input int w);
      @(negedge clk);
      req_valid[w] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      #3;
      if (q_a.size() != 0 || q_b.size() != 0) fail_now("drain_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          waited;
      bit          got;
      logic [31:0] b_addr  [6] = '{32'h40, 32'h44, 32'hFFC, 32'h40, 32'h44, 32'hFFC};
      logic        b_we    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] b_wdata [6] = '{32'h1111_1111, 32'h2222_2222, 32'h7777_7777, 32'h0, 32'h0, 32'h0};
      logic [31:0] b_exp   [6] = '{32'h0, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h7777_7777};

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_addr[i]  = '0;
         req_we[i]    = 1'b0;
         req_wdata[i] = '0;
         req_wstrb[i] = '0;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_req_ready_%0d", i), {31'b0, req_ready[i]}, 32'd1);
         check($sformatf("reset_rsp_valid_%0d", i), {31'b0, rsp_valid[i]}, 32'd0);
         check($sformatf("reset_rsp_rdata_%0d", i), rsp_rdata[i], 32'd0);
         check($sformatf("reset_rsp_err_%0d", i), {31'b0, rsp_err[i]}, 32'd0);
      end

      // Full store, load back, partial store, empty-strobe store, load back.
      issue(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      issue(0, 32'h10, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
      issue(0, 32'h10, 1'b1, 32'h0000_00AA, 4'h1, 32'h0, 1'b0);
      issue(0, 32'h10, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
      issue(0, 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
      issue(0, 32'h10, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
      issue(0, 32'h0,  1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
      idle(0);
      drain();

      // Response back-pressure with a queued request behind it.
      rsp_ready[0] = 1'b0;
      issue(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);
      present(0, 32'h0, 1'b0, 32'h0, 4'h0);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (rsp_valid[0] === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) fail_now("stall_rsp_valid");
      check("stall_req_ready", {31'b0, req_ready[0]}, 32'd0);
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         #1;
         check("stall_req_ready", {31'b0, req_ready[0]}, 32'd0);
         check("stall_rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
      end
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      wait_accept(0, 32'hCAFE_F00D, 1'b0, waited);
      check("stall_release_accept_wait", waited, 32'd0);
      idle(0);
      drain();

      // Misaligned / out-of-range addresses: error flag or index wrap.
      issue(0, 32'h1000, 1'b0, 32'h0, 4'h0, EXP_LD1000, ERR_OOR);
      issue(0, 32'h13,   1'b0, 32'h0, 4'h0, EXP_LD13,   ERR_OOR);
      issue(0, 32'h1000, 1'b1, 32'h5555_5555, 4'hF, 32'h0, ERR_OOR);
      issue(0, 32'h0,    1'b0, 32'h0, 4'h0, EXP_LD0, 1'b0);
      idle(0);
      drain();

      // Reset while a store waits: the store must never land.
      issue(0, 32'h20, 1'b1, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
      issue(0, 32'h20, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
      present(0, 32'h20, 1'b1, 32'h1234_5678, 4'hF);
      wait_accept(0, 32'h0, 1'b0, waited);
      @(negedge clk);
      reset        = 1'b1;
      req_valid[0] = 1'b0;
      #1;
      check("wait_reset_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
      check("wait_reset_req_ready", {31'b0, req_ready[0]}, 32'd1);
      q_a.delete();
      @(negedge clk);
      reset = 1'b0;
      issue(0, 32'h20, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
      idle(0);
      drain();

      // Zero-latency instance: one accept and one response every cycle.
      for (int i = 0; i < 6; i++) begin
         present(1, b_addr[i], b_we[i], b_wdata[i], (b_we[i] ? 4'hF : 4'h0));
         wait_accept(1, b_exp[i], 1'b0, waited);
         check("b2b_accept_wait", waited, 32'd0);
      end
      idle(1);
      drain();

      check("final_queue_a", q_a.size(), 32'd0);
      check("final_queue_b", q_b.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
